// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// Shares one fixed-latency data memory between two requesters:
// port 0 (CPU load/store) and port 1 (debug/DMA loader). Each access
// runs for LAT cycles with registered strobes. It is followed by one
// DONE cycle carrying the winner's ack pulse.
//
// Ports
//   clk, reset                    clock, async active-high reset
//   pN_read, pN_write             request levels (both high = write)
//   pN_addr, pN_wdata             request address / write data
//   pN_rdata                      registered read data, held until next read
//   pN_ack                        one-cycle completion pulse
//   pN_busy_wait                  stall: request present and no ack yet
//   mem_read, mem_write           registered memory strobes
//   mem_addr, mem_wdata           registered memory address / write data
//   mem_rdata                     memory read data, valid in last ACCESS cycle
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_busy_wait,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_busy_wait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  // Granted port of the current/last access; also serves as last_grant
  // for round-robin, since both are updated on the same edge.
  logic               r_gnt;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_p0_rdata;
  logic [DATA_W-1:0]  r_p1_rdata;

  logic               w_p0_req;
  logic               w_p1_req;
  logic               w_any_req;
  logic               w_gnt;
  logic               w_gnt_write;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [DATA_W-1:0]  w_gnt_wdata;
  logic               w_cnt_zero;

  assign w_p0_req   = p0_read | p0_write;
  assign w_p1_req   = p1_read | p1_write;
  assign w_any_req  = w_p0_req | w_p1_req;
  assign w_cnt_zero = (r_cnt == '0);

  // Tie goes to the port that did not win last; otherwise the sole requester.
  assign w_gnt       = (w_p0_req & w_p1_req) ? ~r_gnt : w_p1_req;
  assign w_gnt_write = w_gnt ? p1_write : p0_write;
  assign w_gnt_addr  = w_gnt ? p1_addr  : p0_addr;
  assign w_gnt_wdata = w_gnt ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_cnt_zero) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_gnt       <= 1'b1;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt       <= w_gnt;
            r_mem_read  <= ~w_gnt_write;
            r_mem_write <= w_gnt_write;
            r_mem_addr  <= w_gnt_addr;
            r_mem_wdata <= w_gnt_wdata;
            r_cnt       <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (w_cnt_zero) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read) begin
              if (r_gnt) begin
                r_p1_rdata <= mem_rdata;
              end else begin
                r_p0_rdata <= mem_rdata;
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign p0_ack       = (r_state == S_DONE) & ~r_gnt;
  assign p1_ack       = (r_state == S_DONE) &  r_gnt;
  assign p0_busy_wait = w_p0_req & ~p0_ack;
  assign p1_busy_wait = w_p1_req & ~p1_ack;

  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Testbench for mem_arbiter with default parameters (8-bit, LAT=4) and a
// behavioral 256x8 memory attached to the memory side.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       p0_read, p0_write, p1_read, p1_write;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [7:0] p0_rdata, p1_rdata;
  logic       p0_ack, p1_ack, p0_busy_wait, p1_busy_wait;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256] = '{default: 8'h00};

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_busy_wait(p0_busy_wait),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_busy_wait(p1_busy_wait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic       port;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_wr;
    logic [7:0] exp_r0;
    logic [7:0] exp_r1;
  } vec_t;

  vec_t vecs [11];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic port, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (port) begin
      p1_read = rd; p1_write = wr; p1_addr = a; p1_wdata = d;
    end else begin
      p0_read = rd; p0_write = wr; p0_addr = a; p0_wdata = d;
    end
  endtask

  // Called #1 after a posedge with the arbiter idle; the next edge is E0.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    logic  ack, oack, busy;
    tag = $sformatf("vec%0d", idx);
    drive(v.port, v.rd, v.wr, v.addr, v.wdata);
    for (int c = 0; c < LAT; c++) begin
      @(posedge clk); #1;
      ack  = v.port ? p1_ack : p0_ack;
      busy = v.port ? p1_busy_wait : p0_busy_wait;
      chk1({tag, "_mem_read"},  mem_read,  ~v.exp_wr);
      chk1({tag, "_mem_write"}, mem_write, v.exp_wr);
      chk8({tag, "_mem_addr"},  mem_addr,  v.addr);
      chk8({tag, "_mem_wdata"}, mem_wdata, v.wdata);
      chk1({tag, "_ack_early"}, ack, 1'b0);
      chk1({tag, "_busy"},      busy, 1'b1);
    end
    @(posedge clk); #1;
    ack  = v.port ? p1_ack : p0_ack;
    oack = v.port ? p0_ack : p1_ack;
    busy = v.port ? p1_busy_wait : p0_busy_wait;
    chk1({tag, "_ack"},        ack,  1'b1);
    chk1({tag, "_other_ack"},  oack, 1'b0);
    chk1({tag, "_done_rd"},    mem_read,  1'b0);
    chk1({tag, "_done_wr"},    mem_write, 1'b0);
    chk1({tag, "_busy_ack"},   busy, 1'b0);
    chk8({tag, "_p0_rdata"},   p0_rdata, v.exp_r0);
    chk8({tag, "_p1_rdata"},   p1_rdata, v.exp_r1);
    drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    ack = v.port ? p1_ack : p0_ack;
    chk1({tag, "_ack_once"},   ack, 1'b0);
    chk1({tag, "_idle_rd"},    mem_read, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   nack;
    int   ack_cyc [4];
    logic ack_port [4];

    //          port  rd    wr    addr   wdata  exp_wr r0     r1
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b1, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h20, 8'h3C, 1'b1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h5A, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h11, 1'b1, 8'h5A, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h11, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h11, 8'h3C};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h40, 8'h77, 1'b1, 8'h11, 8'h3C};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h11, 8'h77};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h77};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h77};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF};

    // Reset state, with busy_wait following a request during reset.
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk1("rst_mem_read",  mem_read,  1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk8("rst_mem_addr",  mem_addr,  8'h00);
    chk8("rst_mem_wdata", mem_wdata, 8'h00);
    chk8("rst_p0_rdata",  p0_rdata,  8'h00);
    chk8("rst_p1_rdata",  p1_rdata,  8'h00);
    chk1("rst_p0_ack",    p0_ack,    1'b0);
    chk1("rst_p1_ack",    p1_ack,    1'b0);
    chk1("rst_p0_busy",   p0_busy_wait, 1'b1);
    chk1("rst_p1_busy",   p1_busy_wait, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_hold_rd", mem_read, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Both ports reading continuously from reset: p0, p1, p0, p1, 6 cycles apart.
    pulse_reset();
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    nack = 0;
    for (int c = 1; c <= 40 && nack < 4; c++) begin
      @(posedge clk); #1;
      if (c <= LAT) begin
        chk8("sim_p0_addr", mem_addr, 8'h10);
        chk1("sim_p1_busy", p1_busy_wait, 1'b1);
      end
      if (p0_ack || p1_ack) begin
        ack_cyc[nack]  = c;
        ack_port[nack] = p1_ack;
        nack++;
      end
    end
    chk8("sim_ack_count", 8'(nack), 8'd4);
    for (int i = 0; i < 4 && i < nack; i++) begin
      chk1($sformatf("sim_order%0d", i), ack_port[i], (i % 2) == 1);
      chk8($sformatf("sim_cycle%0d", i), 8'(ack_cyc[i]), 8'(5 + 6 * i));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk8("sim_p0_rdata", p0_rdata, 8'h5A);
    chk8("sim_p1_rdata", p1_rdata, 8'h3C);
    @(posedge clk); #1;

    // p1 write abandoned two cycles into ACCESS still completes.
    drive(1'b1, 1'b0, 1'b1, 8'h50, 8'h99);
    for (int c = 0; c < LAT; c++) begin
      @(posedge clk); #1;
      chk1("abort_mem_write", mem_write, 1'b1);
      chk8("abort_mem_wdata", mem_wdata, 8'h99);
      chk8("abort_mem_addr",  mem_addr,  8'h50);
      if (c == 1) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    @(posedge clk); #1;
    chk1("abort_ack",  p1_ack, 1'b1);
    chk1("abort_busy", p1_busy_wait, 1'b0);
    @(posedge clk); #1;
    v = '{1'b1, 1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 8'h5A, 8'h99};
    run_vec(v, 100);

    // Reset during the second ACCESS cycle discards the transaction.
    drive(1'b0, 1'b1, 1'b0, 8'h04, 8'h00);
    @(posedge clk); #1;
    chk1("rma_started", mem_read, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk1("rma_rd",       mem_read,  1'b0);
    chk1("rma_wr",       mem_write, 1'b0);
    chk1("rma_ack",      p0_ack,    1'b0);
    chk8("rma_p0_rdata", p0_rdata,  8'h00);
    chk8("rma_p1_rdata", p1_rdata,  8'h00);
    chk1("rma_busy",     p0_busy_wait, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk1("rma_no_ack", p0_ack,   1'b0);
      chk1("rma_hold",   mem_read, 1'b0);
    end
    reset = 1'b0;
    v = '{1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h11, 8'h00};
    run_vec(v, 101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port data-memory access controller and arbiter. It shares one fixed-latency 8-bit data memory between two requesters: port 0 (CPU load/store path) and port 1 (debug/DMA loader). It sequences each access over `LAT` cycles, stalls the losing or waiting requester through `busy_wait`, and returns read data with a one-cycle `ack`. It sits between the CPU control unit / register-file write mux and the data memory array.

## Interface
Parameters:
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: data width.
- `LAT`, default 4: memory access cycles, ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `p0_read`, `p0_write`  in  1 each  port 0 request levels.
- `p0_addr`  in  ADDR_W  port 0 address.
- `p0_wdata`  in  DATA_W  port 0 write data.
- `p0_rdata`  out  DATA_W  port 0 read data, registered.
- `p0_ack`  out  1  port 0 completion pulse.
- `p0_busy_wait`  out  1  port 0 stall.
- `p1_read`, `p1_write`, `p1_addr`, `p1_wdata`, `p1_rdata`, `p1_ack`, `p1_busy_wait`: same as port 0, for port 1.
- `mem_read`, `mem_write`  out  1 each  memory strobes, registered.
- `mem_addr`  out  ADDR_W  memory address, registered.
- `mem_wdata`  out  DATA_W  memory write data, registered.
- `mem_rdata`  in  DATA_W  memory read data; valid in the last ACCESS cycle.

## Operation
- A port requests when `read|write` is high. Both high counts as a write.
- `pN_busy_wait = (pN_read|pN_write) & ~pN_ack` (combinational).
- FSM states:
  - IDLE → ACCESS when any request is present.
  - ACCESS → DONE when `cnt==0`.
  - DONE → IDLE unconditionally.
- In IDLE with a request, the arbiter picks the port:
  - Only one port requesting: that port wins.
  - Both requesting: the port not in `last_grant` wins (round-robin).
- On the IDLE → ACCESS transition:
  - Latch grant, op, addr and wdata into `mem_*`.
  - Set `cnt = LAT-1`.
  - Update `last_grant`.
- In ACCESS:
  - Exactly one of `mem_read`/`mem_write` is high.
  - `mem_addr`/`mem_wdata` are stable.
  - `cnt` decrements each cycle.
- On ACCESS → DONE:
  - Deassert the strobes.
  - For a read, capture `mem_rdata` into the granted port's `rdata`.
- In DONE: the granted port's `ack` is high for exactly one cycle.
- `pN_rdata` holds until the next completed read on that port.
- If a requester drops its request mid-access, the access still completes: the write is performed and `ack` still pulses. Input changes after latching are ignored.
- The non-granted port's request stays pending. It is served at the next IDLE evaluation.

## Timing
- Request present before edge E0 (state IDLE):
  - `mem_*` valid from E0 to E_LAT.
  - Read data captured at E_LAT.
  - `ack` high from E_LAT to E_LAT+1.
  - IDLE reached at E_LAT+1.
  - The next request is sampled at E_LAT+2 at the earliest.
- Throughput: one access per LAT+2 cycles. Waiting port latency: up to 2·(LAT+2) cycles.
- LAT=1 gives a single ACCESS cycle; `mem_rdata` is sampled at E1.
- Reset (asynchronous, any state) forces:
  - state IDLE, `cnt=0`;
  - `last_grant=1`, so port 0 wins the first tie;
  - `mem_read`/`mem_write`/`mem_addr`/`mem_wdata`=0;
  - `p0/p1_rdata`=0, `p0/p1_ack`=0.
- Reset mid-ACCESS: strobes drop immediately, no `ack` is issued, and the in-flight transaction is discarded.
- `busy_wait` follows the request level combinationally, including during reset.

## Test plan
- **Port 0 read, LAT=4.** `mem_rdata`=0x5A when strobed, `p0_read` at addr 0x10 before E0. Required: `mem_read` high E0–E4 with `mem_addr`=0x10, `p0_rdata`=0x5A and `p0_ack` pulse at E4, IDLE at E5, `p0_busy_wait` low only during the ack cycle.
- **Port 0 write then read.** Write 0x11 to addr 4, then read addr 4 against a behavioral 256×8 memory. Required: `mem_write` high for 4 cycles with `mem_wdata`=0x11, then the read returns 0x11.
- **Simultaneous requests.** Both ports read (different addrs) continuously after reset. Required: grant order p0, p1, p0, p1; each ack 6 cycles apart; `p1_busy_wait` high throughout p0's access.
- **Abort.** `p1_write` dropped two cycles into ACCESS. Required: the write still occurs for all 4 cycles and `p1_ack` still pulses.
- **Reset mid-access.** `reset` pulsed at cycle 2 of ACCESS. Required: strobes low immediately, no ack, `rdata`=0, and the next request restarts the full 4-cycle sequence.
- **Read+write both high on port 0.** Required: performed as a write (`mem_write`=1, `mem_read`=0); `p0_rdata` unchanged.
